// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - bit-serial multi-cycle ALU sequencer built around a 1-bit slice
module alu_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    // Returns {carry, result_bit}; unknown opcodes yield zero so illegal ops produce 0.
    function automatic logic [1:0] alu_1(input logic [2:0] op, input logic x,
                                         input logic y, input logic ci);
        logic [1:0] r;
        case (op)
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_ADD:  r = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
            OP_XOR:  r = {1'b0, x ^ y};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    logic             is_sub;
    logic             is_arith;
    logic [2:0]       slice_op;
    logic [1:0]       slice;
    logic [WIDTH-1:0] shift_nxt;

    always_comb begin
        is_sub    = (op_q == OP_SUB);
        is_arith  = (op_q == OP_ADD) || is_sub;
        slice_op  = is_arith ? OP_ADD : op_q;
        slice     = alu_1(slice_op, a_q[cnt_q], b_q[cnt_q] ^ is_sub, carry_q);
        shift_nxt = {slice[0], shreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        shreg_d     = shreg_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    op_d    = alu_op;
                    carry_d = (alu_op == OP_SUB);
                    shreg_d = '0;
                end
            end
            S_RUN: begin
                shreg_d = shift_nxt;
                carry_d = slice[1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB, slice[1] the carry out of it
                    state_d     = S_DONE;
                    result_d    = shift_nxt;
                    carry_out_d = is_arith & slice[1];
                    overflow_d  = is_arith & (carry_q ^ slice[1]);
                    zero_d      = (shift_nxt == '0);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            shreg_q     <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_serial.sv
// tb/tb_alu_serial.sv - directed self-checking bench for alu_serial
module tb_alu_serial;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int passes = 0;
    int total  = 0;
    logic [31:0] prev_res = 32'h0;

    alu_serial #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .alu_op(alu_op),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] er, input logic ec,
                          input logic ev, input logic ez);
        int got;
        got = 0;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; alu_op = op;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_held"}, result, prev_res);
        for (int k = 1; k <= WIDTH + 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                got = k;
                break;
            end
        end
        // cycles counted including the one begun by the accepting edge
        chk({tag, "_latency"}, got + 1, WIDTH + 1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, {31'b0, carry_out}, {31'b0, ec});
        chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ev});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'b0, done, busy}, 32'd0);
        prev_res = er;
    endtask

    initial begin
        int ndone;
        int t1;
        int t2;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; alu_op = 3'b000;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, carry_out, overflow, zero}, 32'b001);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_wrap", 3'b010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("sub_neg",  3'b110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  3'b110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("and",      3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        run_op("or",       3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        run_op("xor",      3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
        run_op("illegal",  3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);

        // start held high, inputs scrambled except around the DONE->IDLE->accept window
        ndone = 0; t1 = 0; t2 = 0;
        @(negedge clk);
        start = 1'b1; a = 32'd3; b = 32'd4; alu_op = 3'b010;
        @(posedge clk);
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = c;
                    chk("hold_res1", result, 32'd7);
                end else begin
                    t2 = c;
                    chk("hold_res2", result, 32'd5);
                end
            end
            if (done || (t1 != 0 && c == t1 + 1)) begin
                a = 32'd10; b = 32'd5; alu_op = 3'b110;
            end else begin
                a = $urandom; b = $urandom; alu_op = 3'($urandom_range(0, 7));
            end
            if (c >= 68) start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        chk("hold_ndone", ndone, 32'd2);
        chk("hold_period", t2 - t1, WIDTH + 2);
        prev_res = 32'd5;
        repeat (3) @(posedge clk);

        // reset while bit 10 of an ADD is pending
        @(negedge clk);
        start = 1'b1; a = 32'h00001234; b = 32'd1; alu_op = 3'b010;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        chk("mid_held", result, prev_res);
        #1 reset = 1'b1;
        #1;
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("async_done", {31'b0, done}, 32'd0);
        chk("async_result", result, 32'h0);
        chk("async_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (WIDTH + 6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 32'd0);
        prev_res = 32'h0;
        run_op("add_after_rst", 3'b010, 32'd7, 32'd8, 32'h0000000F, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
